traffic_phase_scheduler: RTL and testbench

Actuated phase scheduler for a two-road intersection with an optional pedestrian crossing. Vehicle-presence sensors for north-south (NS) and east-west (EW) and a pedestrian push-button drive it. It sequences green, yellow, all-red clearance and walk phases under minimum and maximum green limits. The block replaces the fixed-period alternating light controller and drives the NS and EW lamp outputs directly.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/phase_timer.sv | 37 +++
 rtl/traffic_phase_scheduler.sv | 174 +++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the actuated intersection scheduler: phase encoding,
// lamp patterns, direction, and small constant-expression helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Lamp vectors are {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic phase_e opposite_green(input dir_e d);
    return (d == DIR_NS) ? EW_GREEN : NS_GREEN;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state dwell timer: synchronous clear, up-count that stops at sat_val,
// and a ">= term_val" compare used for every state's exit timing.
module phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] sat_val,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         term_hit
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q < sat_val) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign term_hit = (count_q >= term_val);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-road phase scheduler with gap-out/max-out greens.
// Pedestrian walk phase is built only when PED_CROSSING_EN is defined.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 12,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int PED_TIME    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam int LARGEST = max_int(max_int(max_int(GREEN_MIN, GREEN_MAX),
                                           max_int(YELLOW_TIME, ALLRED_TIME)), PED_TIME);
  localparam int TW = $clog2(LARGEST) + 1;

  localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ARED_M1 = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] PED_M1  = TW'(PED_TIME - 1);

  phase_e        state_d, state_q;
  dir_e          last_dir_d, last_dir_q;
  logic [TW-1:0] count, sat_val, term_val;
  logic          term_hit, at_max, timer_clr;
  logic          ns_comp, ew_comp;

`ifdef PED_CROSSING_EN
  logic   ped_pending_d, ped_pending_q;
  phase_e target_d, target_q;

  assign ns_comp = ew_req | ped_pending_q;
  assign ew_comp = ns_req | ped_pending_q;
`else
  logic unused_ped;

  assign unused_ped = ped_req;
  assign ns_comp    = ew_req;
  assign ew_comp    = ns_req;
`endif

  assign at_max    = (count == GMAX_M1);
  assign timer_clr = (state_d != state_q);

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .sat_val  (sat_val),
    .term_val (term_val),
    .count    (count),
    .term_hit (term_hit)
  );

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    sat_val    = '1;
    term_val   = '0;
`ifdef PED_CROSSING_EN
    target_d   = target_q;
`endif
    case (state_q)
      NS_GREEN: begin
        sat_val  = GMAX_M1;
        term_val = GMIN_M1;
        // Own demand keeps green until the max-out cap
        if (ns_comp && term_hit && (!ns_req || at_max)) begin
          state_d    = NS_YELLOW;
          last_dir_d = DIR_NS;
`ifdef PED_CROSSING_EN
          target_d   = ped_pending_q ? PED_WALK : EW_GREEN;
`endif
        end
      end
      EW_GREEN: begin
        sat_val  = GMAX_M1;
        term_val = GMIN_M1;
        if (ew_comp && term_hit && (!ew_req || at_max)) begin
          state_d    = EW_YELLOW;
          last_dir_d = DIR_EW;
`ifdef PED_CROSSING_EN
          target_d   = ped_pending_q ? PED_WALK : NS_GREEN;
`endif
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        term_val = YEL_M1;
        if (term_hit) state_d = ALL_RED;
      end
      ALL_RED: begin
        term_val = ARED_M1;
        if (term_hit) begin
`ifdef PED_CROSSING_EN
          state_d = target_q;
`else
          state_d = opposite_green(last_dir_q);
`endif
        end
      end
`ifdef PED_CROSSING_EN
      PED_WALK: begin
        term_val = PED_M1;
        if (term_hit) begin
          state_d  = ALL_RED;
          target_d = opposite_green(last_dir_q);
        end
      end
`endif
      default: state_d = ALL_RED;
    endcase
  end

`ifdef PED_CROSSING_EN
  // Walk entry clears the request even if the button is pressed that cycle
  always_comb begin
    ped_pending_d = ped_pending_q | (ped_req && (state_q != PED_WALK));
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) ped_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
      target_q      <= EW_GREEN;
    end else begin
      ped_pending_q <= ped_pending_d;
      target_q      <= target_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= NS_GREEN;
      last_dir_q <= DIR_NS;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    ped_walk = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = LAMP_GRN;
      NS_YELLOW: ns_light = LAMP_YEL;
      EW_GREEN:  ew_light = LAMP_GRN;
      EW_YELLOW: ew_light = LAMP_YEL;
`ifdef PED_CROSSING_EN
      PED_WALK:  ped_walk = 1'b1;
`endif
      default: begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: per-edge phase table plus a
// mid-yellow reset sequence; lamp/walk expectations come from the phase.
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       reset;
  logic       ns_req, ew_req, ped_req;
  logic [2:0] ns_light, ew_light, phase;
  logic       ped_walk;

  int n_vec;
  int n_err;

  typedef struct {
    bit         rst;
    bit         ns;
    bit         ew;
    bit         ped;
    int         n;
    logic [2:0] ph;
  } vec_t;

  vec_t vecs[$];

  traffic_phase_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .ns_req   (ns_req),
    .ew_req   (ew_req),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps per phase, {R,Y,G}
  task automatic exp_lamps(input logic [2:0] ph, output logic [2:0] e_ns,
                           output logic [2:0] e_ew, output logic e_walk);
    e_ns = 3'b100; e_ew = 3'b100; e_walk = 1'b0;
    case (ph)
      3'd0: e_ns = 3'b001;
      3'd1: e_ns = 3'b010;
      3'd3: e_ew = 3'b001;
      3'd4: e_ew = 3'b010;
      3'd5: e_walk = 1'b1;
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [2:0] ph);
    logic [2:0] e_ns, e_ew;
    logic       e_walk;
    exp_lamps(ph, e_ns, e_ew, e_walk);
    n_vec++;
    if (phase !== ph || ns_light !== e_ns || ew_light !== e_ew || ped_walk !== e_walk) begin
      n_err++;
      $display("FAIL %s: got phase=%0d ns=%b ew=%b walk=%b, want phase=%0d ns=%b ew=%b walk=%b",
               tag, phase, ns_light, ew_light, ped_walk, ph, e_ns, e_ew, e_walk);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    #1 check(tag, 3'd0);
    @(posedge clk);
  endtask

  task automatic step(input bit ns, input bit ew, input bit ped,
                      input logic [2:0] ph, input string tag);
    @(negedge clk);
    reset = 1'b0; ns_req = ns; ew_req = ew; ped_req = ped;
    @(posedge clk);
    #1 check(tag, ph);
  endtask

  task automatic add(input bit rst, input bit ns, input bit ew, input bit ped,
                     input int n, input logic [2:0] ph);
    vec_t v;
    v.rst = rst; v.ns = ns; v.ew = ew; v.ped = ped; v.n = n; v.ph = ph;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;

    // idle: NS green holds
    add(1, 0, 0, 0, 50, 3'd0);
    // EW demand only: 4 green, 2 yellow, 1 all-red, EW green holds
    add(1, 0, 1, 0, 3, 3'd0);
    add(0, 0, 1, 0, 2, 3'd1);
    add(0, 0, 1, 0, 1, 3'd2);
    add(0, 0, 1, 0, 8, 3'd3);
    // both held: 12-cycle max-out greens alternate
    add(1, 1, 1, 0, 11, 3'd0);
    add(0, 1, 1, 0, 2, 3'd1);
    add(0, 1, 1, 0, 1, 3'd2);
    add(0, 1, 1, 0, 12, 3'd3);
    add(0, 1, 1, 0, 2, 3'd4);
    add(0, 1, 1, 0, 1, 3'd2);
    add(0, 1, 1, 0, 12, 3'd0);
    add(0, 1, 1, 0, 2, 3'd1);
    // gap-out: own demand drops after minimum green
    add(1, 1, 1, 0, 6, 3'd0);
    add(0, 0, 1, 0, 1, 3'd1);
    add(0, 0, 1, 0, 1, 3'd1);
    add(0, 0, 1, 0, 1, 3'd2);
    add(0, 0, 1, 0, 3, 3'd3);
`ifdef PED_CROSSING_EN
    // ped pulse: 4 green, 2 yellow, 1 all-red, 6 walk, 1 all-red, EW green
    add(1, 0, 0, 1, 1, 3'd0);
    add(0, 0, 0, 0, 2, 3'd0);
    add(0, 0, 0, 0, 2, 3'd1);
    add(0, 0, 0, 0, 1, 3'd2);
    add(0, 0, 0, 0, 3, 3'd5);
    add(0, 0, 0, 1, 1, 3'd5);
    add(0, 0, 0, 0, 2, 3'd5);
    add(0, 0, 0, 0, 1, 3'd2);
    add(0, 0, 0, 0, 20, 3'd3);
`else
    // button ignored without the crossing
    add(1, 0, 0, 1, 1, 3'd0);
    add(0, 0, 0, 0, 20, 3'd0);
    add(0, 0, 0, 1, 3, 3'd0);
    add(0, 0, 0, 0, 20, 3'd0);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset($sformatf("reset_row%0d", i));
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].ns, vecs[i].ew, vecs[i].ped, vecs[i].ph,
             $sformatf("row%0d_edge%0d", i, k));
      end
    end

    // reset during EW yellow with a pedestrian request pending
    do_reset("mid_reset_pre");
    for (int k = 0; k < 3; k++) step(0, 1, 0, 3'd0, "mid_nsg");
    for (int k = 0; k < 2; k++) step(0, 1, 0, 3'd1, "mid_nsy");
    step(0, 1, 0, 3'd2, "mid_allred");
    step(0, 1, 0, 3'd3, "mid_ewg_entry");
    step(1, 0, 1, 3'd3, "mid_ewg_ped");
    for (int k = 0; k < 2; k++) step(1, 0, 0, 3'd3, "mid_ewg");
    step(1, 0, 0, 3'd4, "mid_ewy");
    @(negedge clk);
    reset = 1'b1; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    #1 check("mid_reset_async", 3'd0);
    for (int k = 0; k < 30; k++) step(0, 0, 0, 3'd0, "post_reset_no_walk");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
